// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel, run-time-programmable clock divider.
// Each channel produces a 50%-duty divided waveform (period 2*D cycles)
// and a one-cycle tick strobe every D cycles. New divisors are written
// into a shadow register and take effect at the channel's next wrap, or
// at once on a sync restart, so no period ever mixes two divisors.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   en           global count enable (counters hold while low)
//   sync         restart all channels from count 0, slow_clk low
//   div_load     write strobe for a channel divisor
//   div_ch       channel index for div_load (>= NUM_CH ignored)
//   div_value    divisor to write (0 behaves as 1)
//   slow_clk     per-channel divided waveform
//   tick         per-channel one-cycle strobe
//   div_pending  per-channel: a loaded divisor is waiting for a wrap
module clk_div_multi #(
  parameter int unsigned        NUM_CH      = 4,
  parameter int unsigned        CNT_W       = 16,
  parameter logic [CNT_W-1:0]   DEFAULT_DIV = CNT_W'(50000)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              sync,
  input  logic              div_load,
  input  logic [2:0]        div_ch,
  input  logic [CNT_W-1:0]  div_value,
  output logic [NUM_CH-1:0] slow_clk,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] div_pending
);

  localparam int unsigned CH_IDX_W = 3;

  logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][CNT_W-1:0] act_q, act_d;
  logic [NUM_CH-1:0][CNT_W-1:0] sh_q,  sh_d;
  logic [NUM_CH-1:0]            pend_q, pend_d;
  logic [NUM_CH-1:0]            slow_q, slow_d;
  logic [NUM_CH-1:0]            tick_q, tick_d;

  logic [NUM_CH-1:0][CNT_W-1:0] last_c;
  logic [NUM_CH-1:0]            wrap_c;
  logic [NUM_CH-1:0]            ld_hit_c;
  logic [NUM_CH-1:0]            apply_c;

  // Per-channel terminal count (act=0 treated as D=1), wrap and load decode.
  always_comb begin
    last_c   = '0;
    wrap_c   = '0;
    ld_hit_c = '0;
    apply_c  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      last_c[i]   = (act_q[i] == '0) ? '0 : act_q[i] - CNT_W'(1);
      wrap_c[i]   = (cnt_q[i] == last_c[i]);
      ld_hit_c[i] = div_load && (div_ch == CH_IDX_W'(i));
      // A divisor swap happens only at a period boundary: wrap or sync.
      apply_c[i]  = sync || (en && wrap_c[i]);
    end
  end

  // Next-state: counting, then divisor shadow/apply handling.
  always_comb begin
    cnt_d  = cnt_q;
    act_d  = act_q;
    sh_d   = sh_q;
    pend_d = pend_q;
    slow_d = slow_q;
    tick_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sync) begin
        cnt_d[i]  = '0;
        slow_d[i] = 1'b0;
      end else if (en) begin
        if (wrap_c[i]) begin
          cnt_d[i]  = '0;
          tick_d[i] = 1'b1;
          slow_d[i] = ~slow_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end

      if (apply_c[i]) begin
        // A write landing on the boundary bypasses the shadow.
        if (ld_hit_c[i]) begin
          act_d[i]  = div_value;
          sh_d[i]   = div_value;
          pend_d[i] = 1'b0;
        end else if (pend_q[i]) begin
          act_d[i]  = sh_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (ld_hit_c[i]) begin
        sh_d[i]   = div_value;
        pend_d[i] = 1'b1;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      act_q  <= {NUM_CH{DEFAULT_DIV}};
      sh_q   <= {NUM_CH{DEFAULT_DIV}};
      pend_q <= '0;
      slow_q <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      sh_q   <= sh_d;
      pend_q <= pend_d;
      slow_q <= slow_d;
      tick_q <= tick_d;
    end
  end

  assign slow_clk    = slow_q;
  assign tick        = tick_q;
  assign div_pending = pend_q;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed testbench for clk_div_multi with DEFAULT_DIV=4, NUM_CH=4.
module tb_clk_div_multi;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CNT_W  = 16;

  logic              clk;
  logic              reset;
  logic              en;
  logic              sync;
  logic              div_load;
  logic [2:0]        div_ch;
  logic [CNT_W-1:0]  div_value;
  logic [NUM_CH-1:0] slow_clk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] div_pending;

  int checks;
  int errors;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (16'd4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .sync        (sync),
    .div_load    (div_load),
    .div_ch      (div_ch),
    .div_value   (div_value),
    .slow_clk    (slow_clk),
    .tick        (tick),
    .div_pending (div_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset, then release with en=1; the next edge is edge 1.
  task automatic do_reset();
    reset = 1'b0; en = 1'b0; sync = 1'b0;
    div_load = 1'b0; div_ch = '0; div_value = '0;
    step();
    step();
    reset = 1'b1;
    en    = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    reset = 1'b0;
    #2;
    if (tick !== 4'h0) begin errors++; $display("FAIL reset_tick got=%h exp=0", tick); end
    checks++;
    if (slow_clk !== 4'h0) begin errors++; $display("FAIL reset_slow got=%h exp=0", slow_clk); end
    checks++;
    if (div_pending !== 4'h0) begin errors++; $display("FAIL reset_pend got=%h exp=0", div_pending); end
    checks++;
  endtask

  // All channels at D=4: tick every 4th edge, slow_clk period 8.
  task automatic test_default();
    logic [3:0] et, es;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      et = (k % 4 == 0) ? 4'hF : 4'h0;
      es = (((k / 4) % 2) == 1) ? 4'hF : 4'h0;
      if (tick !== et) begin errors++; $display("FAIL default_tick edge=%0d got=%h exp=%h", k, tick, et); end
      checks++;
      if (slow_clk !== es) begin errors++; $display("FAIL default_slow edge=%0d got=%h exp=%h", k, slow_clk, es); end
      checks++;
    end
  endtask

  // Ch1 loaded with 3 mid-period: finishes its 4-period, then ticks every 3.
  task automatic test_load_mid();
    logic [3:0] et;
    logic       es1;
    do_reset();
    step();                                   // edge 1
    div_load = 1'b1; div_ch = 3'd1; div_value = 16'd3;
    step();                                   // edge 2
    div_load = 1'b0;
    if (div_pending !== 4'b0010) begin errors++; $display("FAIL load_pend_e2 got=%b exp=0010", div_pending); end
    checks++;
    step();                                   // edge 3
    if (div_pending !== 4'b0010) begin errors++; $display("FAIL load_pend_e3 got=%b exp=0010", div_pending); end
    checks++;
    step();                                   // edge 4: wrap applies 3
    if (div_pending !== 4'b0000) begin errors++; $display("FAIL load_pend_e4 got=%b exp=0000", div_pending); end
    checks++;
    if (tick !== 4'hF) begin errors++; $display("FAIL load_tick_e4 got=%h exp=f", tick); end
    checks++;
    for (int k = 5; k <= 13; k++) begin
      step();
      et = (k % 4 == 0) ? 4'b1101 : 4'b0000;
      if ((k - 4) % 3 == 0) et[1] = 1'b1;
      es1 = (((k - 4) / 3) % 2 == 0) ? 1'b1 : 1'b0;
      if (tick !== et) begin errors++; $display("FAIL load_tick edge=%0d got=%b exp=%b", k, tick, et); end
      checks++;
      if (slow_clk[1] !== es1) begin errors++; $display("FAIL load_slow1 edge=%0d got=%b exp=%b", k, slow_clk[1], es1); end
      checks++;
    end
  endtask

  // Ch2 divisor 0 then 1 (the latter loaded on a wrap edge).
  task automatic test_div01();
    logic es2;
    do_reset();
    div_load = 1'b1; div_ch = 3'd2; div_value = 16'd0;
    step();                                   // edge 1
    div_load = 1'b0;
    step(); step(); step();                   // edges 2..4, wrap applies 0
    for (int k = 5; k <= 12; k++) begin
      if (k == 9) begin
        div_load = 1'b1; div_ch = 3'd2; div_value = 16'd1;
      end
      step();
      div_load = 1'b0;
      es2 = ((k - 4) % 2 == 0) ? 1'b1 : 1'b0;
      if (tick[2] !== 1'b1) begin errors++; $display("FAIL div01_tick edge=%0d got=%b exp=1", k, tick[2]); end
      checks++;
      if (slow_clk[2] !== es2) begin errors++; $display("FAIL div01_slow edge=%0d got=%b exp=%b", k, slow_clk[2], es2); end
      checks++;
      if (k == 9 && div_pending !== 4'b0000) begin
        errors++; $display("FAIL div01_pend_wrapload got=%b exp=0000", div_pending);
      end
      if (k == 9) checks++;
    end
  endtask

  // Sync phase-aligns D=4/6/5/6 channels and applies pending divisors.
  task automatic test_sync();
    int         dv [4];
    logic [3:0] et;
    dv[0] = 4; dv[1] = 6; dv[2] = 5; dv[3] = 6;
    do_reset();
    div_load = 1'b1; div_ch = 3'd1; div_value = 16'd6;
    step();                                   // edge 1
    div_load = 1'b0;
    for (int k = 2; k <= 6; k++) step();
    div_load = 1'b1; div_ch = 3'd2; div_value = 16'd5;
    step();                                   // edge 7
    if (div_pending !== 4'b0100) begin errors++; $display("FAIL sync_pend_pre got=%b exp=0100", div_pending); end
    checks++;
    sync = 1'b1; div_load = 1'b1; div_ch = 3'd3; div_value = 16'd6;
    step();                                   // edge 8: sync
    sync = 1'b0; div_load = 1'b0;
    if (tick !== 4'h0 || slow_clk !== 4'h0) begin
      errors++; $display("FAIL sync_clear tick=%h slow=%h exp=0,0", tick, slow_clk);
    end
    checks++;
    if (div_pending !== 4'b0000) begin errors++; $display("FAIL sync_pend_post got=%b exp=0000", div_pending); end
    checks++;
    for (int j = 1; j <= 12; j++) begin
      step();
      et = '0;
      for (int c = 0; c < 4; c++) et[c] = (j % dv[c] == 0);
      if (tick !== et) begin errors++; $display("FAIL sync_tick j=%0d got=%b exp=%b", j, tick, et); end
      checks++;
    end
    if (slow_clk !== 4'b0001) begin errors++; $display("FAIL sync_slow_j12 got=%b exp=0001", slow_clk); end
    checks++;
  endtask

  // Freeze at cnt=3 for 5 edges, load ch0 while frozen, then resume.
  task automatic test_enable();
    do_reset();
    for (int k = 1; k <= 7; k++) step();      // cnt=3, slow=F
    en = 1'b0;
    div_load = 1'b1; div_ch = 3'd0; div_value = 16'd2;
    for (int k = 8; k <= 12; k++) begin
      step();
      div_load = 1'b0;
      if (tick !== 4'h0 || slow_clk !== 4'hF) begin
        errors++; $display("FAIL en_freeze edge=%0d tick=%h slow=%h exp=0,f", k, tick, slow_clk);
      end
      checks++;
    end
    if (div_pending !== 4'b0001) begin errors++; $display("FAIL en_pend got=%b exp=0001", div_pending); end
    checks++;
    en = 1'b1;
    step();                                   // edge 13: the held wrap
    if (tick !== 4'hF || slow_clk !== 4'h0) begin
      errors++; $display("FAIL en_resume tick=%h slow=%h exp=f,0", tick, slow_clk);
    end
    checks++;
    if (div_pending !== 4'b0000) begin errors++; $display("FAIL en_apply got=%b exp=0000", div_pending); end
    checks++;
    step(); step();                           // edge 15: ch0 at D=2
    if (tick !== 4'b0001) begin errors++; $display("FAIL en_newdiv got=%b exp=0001", tick); end
    checks++;
  endtask

  // Out-of-range channel ignored; async reset discards pending load.
  task automatic test_badch_reset();
    do_reset();
    div_load = 1'b1; div_ch = 3'd7; div_value = 16'd2;
    step();                                   // edge 1
    div_load = 1'b0;
    if (div_pending !== 4'h0) begin errors++; $display("FAIL badch_pend got=%b exp=0000", div_pending); end
    checks++;
    step(); step(); step();                   // edge 4
    if (tick !== 4'hF) begin errors++; $display("FAIL badch_tick got=%h exp=f", tick); end
    checks++;
    div_load = 1'b1; div_ch = 3'd0; div_value = 16'd3;
    step();                                   // edge 5
    div_load = 1'b0;
    if (div_pending !== 4'b0001) begin errors++; $display("FAIL rst_pend_pre got=%b exp=0001", div_pending); end
    checks++;
    #2 reset = 1'b0;
    #1;
    if (slow_clk !== 4'h0 || tick !== 4'h0 || div_pending !== 4'h0) begin
      errors++; $display("FAIL rst_async slow=%h tick=%h pend=%h exp=0,0,0", slow_clk, tick, div_pending);
    end
    checks++;
    step();
    reset = 1'b1;
    step(); step(); step();                   // edge 3: D=3 would tick here
    if (tick !== 4'h0) begin errors++; $display("FAIL rst_e3 got=%h exp=0", tick); end
    checks++;
    step();                                   // edge 4
    if (tick !== 4'hF) begin errors++; $display("FAIL rst_e4 got=%h exp=f", tick); end
    checks++;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_default();
    test_load_mid();
    test_div01();
    test_sync();
    test_enable();
    test_badch_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
